// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared FSM state type and width helper for the SDRAM multi-channel arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ARB, WR_BURST, RD_BURST} state_t;

    // Index width that never collapses to zero bits for single-entry structures.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// sdram_arb_tag_fifo: synchronous FIFO of channel tags for outstanding read bursts.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int IW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [IW-1:0] wr_idx, rd_idx;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    assign full    = cnt == CW'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_idx <= (wr_idx == IW'(DEPTH - 1)) ? '0 : wr_idx + 1'b1;
            if (do_pop)  rd_idx <= (rd_idx == IW'(DEPTH - 1)) ? '0 : rd_idx + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end

    always_ff @(posedge clk)
        if (do_push) mem[wr_idx] <= din;

endmodule

// File: rtl/sdram_multi_arbiter.sv
// sdram_multi_arbiter: round-robin burst arbiter sharing one SDRAM controller between NUM_CH clients,
// with per-channel address windows and tag-routed read returns.
module sdram_multi_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ADDR_BITS = 21,
    parameter int DATA_BITS = 32,
    parameter int BURST_LEN = 8,
    parameter int CH_SPAN   = 307200,
    parameter int TAG_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CH-1:0]                 ch_enable,
    input  logic [NUM_CH-1:0]                 ch_req,
    input  logic [NUM_CH-1:0]                 ch_we,
    input  logic [NUM_CH*ADDR_BITS-1:0]       ch_addr,
    input  logic [NUM_CH*DATA_BITS-1:0]       ch_wr_din,
    input  logic [NUM_CH*DATA_BITS/8-1:0]     ch_wr_dm,
    output logic [NUM_CH-1:0]                 ch_gnt,
    output logic [NUM_CH-1:0]                 ch_wr_next,
    output logic [NUM_CH-1:0]                 ch_rd_valid,
    output logic [DATA_BITS-1:0]              ch_rd_dout,
    input  logic                              sdram_ready,
    output logic                              sdram_App_wr_en,
    output logic [ADDR_BITS-1:0]              sdram_App_wr_addr,
    output logic [DATA_BITS-1:0]              sdram_App_wr_din,
    output logic [DATA_BITS/8-1:0]            sdram_App_wr_dm,
    output logic                              sdram_App_rd_en,
    output logic [ADDR_BITS-1:0]              sdram_App_rd_addr,
    input  logic                              sdram_Sdr_rd_en,
    input  logic [DATA_BITS-1:0]              sdram_Sdr_rd_dout,
    output logic                              err_orphan
);
    localparam int A      = ADDR_BITS;
    localparam int D      = DATA_BITS;
    localparam int M      = DATA_BITS / 8;
    localparam int CH_W   = clog2_min1(NUM_CH);
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;

    state_t              state, state_nxt;
    logic [CH_W-1:0]     rr_ptr, sel, arb_ch, idx, head;
    logic [A-1:0]        phys, addr;
    logic [BEAT_W-1:0]   beat, ret_cnt;
    logic [NUM_CH-1:0]   elig, rd_valid_q;
    logic [D-1:0]        rd_dout_q;
    logic                found, strobe, last, fifo_full, fifo_empty, push, pop, err_q;

    // Reads need a free tag slot; writes are always eligible.
    assign elig = ch_req & ch_enable & (ch_we | {NUM_CH{~fifo_full}});

    always_comb begin
        found  = 1'b0;
        arb_ch = '0;
        idx    = rr_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && elig[idx]) begin
                found  = 1'b1;
                arb_ch = idx;
            end
            idx = (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = |(ch_req & ch_enable) ? ARB : IDLE;
            ARB:     state_nxt = !found ? IDLE : ch_we[arb_ch] ? WR_BURST : RD_BURST;
            default: state_nxt = (strobe && last) ? IDLE : state;
        endcase
    end

    assign strobe            = sdram_ready && (state == WR_BURST || state == RD_BURST);
    assign last              = beat == BEAT_W'(BURST_LEN - 1);
    assign addr              = phys + A'(beat);
    assign sdram_App_wr_en   = strobe && state == WR_BURST;
    assign sdram_App_rd_en   = strobe && state == RD_BURST;
    assign sdram_App_wr_addr = sdram_App_wr_en ? addr : '0;
    assign sdram_App_rd_addr = sdram_App_rd_en ? addr : '0;
    assign sdram_App_wr_din  = sdram_App_wr_en ? ch_wr_din[int'(sel)*D +: D] : '0;
    assign sdram_App_wr_dm   = sdram_App_wr_en ? ch_wr_dm[int'(sel)*M +: M] : '0;
    assign ch_wr_next        = sdram_App_wr_en ? NUM_CH'(1) << sel : '0;
    assign ch_gnt            = (state == ARB && found) ? NUM_CH'(1) << arb_ch : '0;
    assign push              = state == ARB && found && !ch_we[arb_ch];
    assign pop               = sdram_Sdr_rd_en && !fifo_empty && ret_cnt == BEAT_W'(BURST_LEN - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            sel    <= '0;
            phys   <= '0;
            beat   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB && found) begin
                sel    <= arb_ch;
                phys   <= ch_addr[int'(arb_ch)*A +: A] + A'(int'(arb_ch) * CH_SPAN);
                rr_ptr <= (arb_ch == CH_W'(NUM_CH - 1)) ? '0 : arb_ch + 1'b1;
                beat   <= '0;
            end else if (strobe) begin
                beat <= last ? '0 : beat + 1'b1;
            end
        end

    // Return path runs independently of the FSM so reads can overlap new grants.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_valid_q <= '0;
            rd_dout_q  <= '0;
            ret_cnt    <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= (sdram_Sdr_rd_en && !fifo_empty) ? NUM_CH'(1) << head : '0;
            if (sdram_Sdr_rd_en) rd_dout_q <= sdram_Sdr_rd_dout;
            if (sdram_Sdr_rd_en && fifo_empty) err_q <= 1'b1;
            if (sdram_Sdr_rd_en && !fifo_empty) ret_cnt <= pop ? '0 : ret_cnt + 1'b1;
        end

    assign ch_rd_valid = rd_valid_q;
    assign ch_rd_dout  = rd_dout_q;
    assign err_orphan  = err_q;

    sdram_arb_tag_fifo #(.W(CH_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (arb_ch),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
